// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i widths and the execute-stage resolve bundle
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic            predicted_taken;
        logic [XLEN-1:0] pc_next;
        logic [XLEN-1:0] target;
    } resolve_t;

endpackage

// File: rtl/branch_evaluator.sv
// rtl/branch_evaluator.sv - resolves actual branch direction from the ALU zero flag
module branch_evaluator (
    input  logic ex_jump,
    input  logic ex_branch,
    input  logic branch_if_zero,
    input  logic zero,
    output logic branch_taken
);

    assign branch_taken = ex_jump | (ex_branch & (branch_if_zero == zero));

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - static BTFN predictor, jumps always taken
module branch_predictor #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_next,
    input  logic [XLEN-1:0] immediate,
    input  logic            jump,
    input  logic            branch,
    output logic [XLEN-1:0] branch_target,
    output logic            branch_taken_predicted
);

    // A negative offset means a backward branch, which is usually a loop.
    assign branch_taken_predicted = jump | (branch & immediate[XLEN-1]);
    assign branch_target = branch_taken_predicted ? pc_next + immediate : pc_next;

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - prediction, resolution, redirect pulse and saturating statistics
module branch_unit #(
    parameter int XLEN  = rv32i_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  pc_next,
    input  logic [XLEN-1:0]  immediate,
    input  logic             jump,
    input  logic             branch,
    output logic [XLEN-1:0]  branch_target,
    output logic             branch_taken_predicted,
    input  logic             ex_valid,
    input  logic             ex_jump,
    input  logic             ex_branch,
    input  logic             branch_if_zero,
    input  logic             zero,
    input  logic             ex_predicted_taken,
    input  logic [XLEN-1:0]  ex_pc_next,
    input  logic [XLEN-1:0]  ex_target,
    output logic             branch_taken,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    import rv32i_pkg::*;

    resolve_t ex_req;
    logic     resolve;
    logic     wrong;

    assign ex_req.predicted_taken = ex_predicted_taken;
    assign ex_req.pc_next         = ex_pc_next;
    assign ex_req.target          = ex_target;

    branch_predictor #(.XLEN(XLEN)) u_predictor (
        .pc_next                (pc_next),
        .immediate              (immediate),
        .jump                   (jump),
        .branch                 (branch),
        .branch_target          (branch_target),
        .branch_taken_predicted (branch_taken_predicted)
    );

    branch_evaluator u_evaluator (
        .ex_jump        (ex_jump),
        .ex_branch      (ex_branch),
        .branch_if_zero (branch_if_zero),
        .zero           (zero),
        .branch_taken   (branch_taken)
    );

    assign resolve = ex_valid & (ex_jump | ex_branch);
    assign wrong   = resolve & (branch_taken != ex_req.predicted_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict       <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= wrong;
            if (wrong) begin
                redirect_pc <= branch_taken ? ex_req.target : ex_req.pc_next;
            end
            // Counters stick at all-ones rather than wrapping back to zero.
            if (resolve && (branch_count != '1)) begin
                branch_count <= branch_count + 1'b1;
            end
            if (wrong && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - directed and randomized checks of branch_unit against a reference model
module tb_branch_unit;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [XLEN-1:0]  pc_next = '0;
    logic [XLEN-1:0]  immediate = '0;
    logic             jump = 1'b0;
    logic             branch = 1'b0;
    logic [XLEN-1:0]  branch_target;
    logic             branch_taken_predicted;
    logic             ex_valid = 1'b0;
    logic             ex_jump = 1'b0;
    logic             ex_branch = 1'b0;
    logic             branch_if_zero = 1'b0;
    logic             zero = 1'b0;
    logic             ex_predicted_taken = 1'b0;
    logic [XLEN-1:0]  ex_pc_next = '0;
    logic [XLEN-1:0]  ex_target = '0;
    logic             branch_taken;
    logic             mispredict;
    logic [XLEN-1:0]  redirect_pc;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    int tests = 0;
    int failed = 0;

    logic            m_misp = 1'b0;
    logic [XLEN-1:0] m_redir = '0;
    int              m_bc = 0;
    int              m_mc = 0;

    branch_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .pc_next                (pc_next),
        .immediate              (immediate),
        .jump                   (jump),
        .branch                 (branch),
        .branch_target          (branch_target),
        .branch_taken_predicted (branch_taken_predicted),
        .ex_valid               (ex_valid),
        .ex_jump                (ex_jump),
        .ex_branch              (ex_branch),
        .branch_if_zero         (branch_if_zero),
        .zero                   (zero),
        .ex_predicted_taken     (ex_predicted_taken),
        .ex_pc_next             (ex_pc_next),
        .ex_target              (ex_target),
        .branch_taken           (branch_taken),
        .mispredict             (mispredict),
        .redirect_pc            (redirect_pc),
        .branch_count           (branch_count),
        .mispredict_count       (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit m_predict(input bit j, input bit b, input logic [XLEN-1:0] imm);
        if (j) return 1'b1;
        return b && ($signed(imm) < 0);
    endfunction

    function automatic bit m_resolve(input bit j, input bit b, input bit bz, input bit z);
        if (j) return 1'b1;
        if (b) return bz == z;
        return 1'b0;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic check_regs();
        chk("mispredict", {31'd0, mispredict}, {31'd0, m_misp});
        chk("redirect_pc", redirect_pc, m_redir);
        chk("branch_count", {26'd0, branch_count}, m_bc[XLEN-1:0]);
        chk("mispredict_count", {26'd0, mispredict_count}, m_mc[XLEN-1:0]);
    endtask

    task automatic check_comb();
        bit              p;
        bit              t;
        logic [XLEN-1:0] tgt;
        p   = m_predict(jump, branch, immediate);
        tgt = p ? (pc_next + immediate) : pc_next;
        t   = m_resolve(ex_jump, ex_branch, branch_if_zero, zero);
        chk("predicted", {31'd0, branch_taken_predicted}, {31'd0, p});
        chk("branch_target", branch_target, tgt);
        chk("branch_taken", {31'd0, branch_taken}, {31'd0, t});
    endtask

    // Inputs are held from here through the rising edge; registered outputs checked 1ns after it.
    task automatic tick();
        bit t;
        #1;
        check_comb();
        @(posedge clk);
        t = m_resolve(ex_jump, ex_branch, branch_if_zero, zero);
        m_misp = 1'b0;
        if (ex_valid && (ex_jump || ex_branch)) begin
            m_bc = sat_inc(m_bc);
            if (t != ex_predicted_taken) begin
                m_misp  = 1'b1;
                m_redir = t ? ex_target : ex_pc_next;
                m_mc    = sat_inc(m_mc);
            end
        end
        #1;
        check_regs();
    endtask

    task automatic model_reset();
        m_misp  = 1'b0;
        m_redir = '0;
        m_bc    = 0;
        m_mc    = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_regs();
        rst_n = 1'b1;

        pc_next = 32'd12; immediate = 32'd20;
        tick();
        chk("static_target", branch_target, 32'd12);

        jump = 1'b1; ex_jump = 1'b1;
        tick();
        chk("jump_target", branch_target, 32'd32);

        jump = 1'b0; branch = 1'b1; ex_jump = 1'b0; ex_branch = 1'b1;
        branch_if_zero = 1'b1; zero = 1'b1; ex_valid = 1'b1;
        ex_predicted_taken = 1'b0; ex_target = 32'd40;
        tick();
        chk("fwd_redirect", redirect_pc, 32'd40);

        immediate = 32'hFFFF_FFFC; branch_if_zero = 1'b0;
        ex_predicted_taken = 1'b1; ex_pc_next = 32'd16;
        tick();
        chk("back_target", branch_target, 32'd8);
        chk("back_redirect", redirect_pc, 32'd16);

        ex_predicted_taken = 1'b0;
        tick();
        ex_valid = 1'b0;
        tick();

        for (int i = 0; i < 300; i++) begin
            pc_next            = $urandom;
            immediate          = $urandom;
            jump               = 1'($urandom_range(0, 1));
            branch             = 1'($urandom_range(0, 1));
            ex_valid           = 1'($urandom_range(0, 3) != 0);
            ex_jump            = 1'($urandom_range(0, 3) == 0);
            ex_branch          = 1'($urandom_range(0, 1));
            branch_if_zero     = 1'($urandom_range(0, 1));
            zero               = 1'($urandom_range(0, 1));
            ex_predicted_taken = 1'($urandom_range(0, 1));
            ex_pc_next         = $urandom;
            ex_target          = $urandom;
            tick();
        end

        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        ex_valid = 1'b1; ex_jump = 1'b1; ex_branch = 1'b0; ex_predicted_taken = 1'b0;
        for (int i = 0; i < CMAX + 6; i++) begin
            ex_target = $urandom;
            tick();
        end
        chk("sat_branch_count", {26'd0, branch_count}, CMAX);
        chk("sat_mispredict_count", {26'd0, mispredict_count}, CMAX);

        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_comb();
        @(negedge clk);
        rst_n = 1'b1;
        ex_valid = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
